// File: rtl/btn_event_decoder.sv
// rtl/btn_event_decoder.sv - classifies a debounced button level into short/double/long/repeat pulses
// All gesture timing is counted in prescaler ticks; the prescaler free-runs, so timeouts carry -1 tick of jitter.
module btn_event_decoder #(
    parameter int CLK_FREQ     = 100_000_000,
    parameter int TICK_HZ      = 1000,
    parameter int LONG_TICKS   = 800,
    parameter int DBL_TICKS    = 250,
    parameter int REPEAT_TICKS = 100
) (
    input  logic clk,
    input  logic reset,
    input  logic i_btn,
    output logic o_short,
    output logic o_double,
    output logic o_long,
    output logic o_repeat,
    output logic o_pressed
);

    localparam int PRESCALE = CLK_FREQ / TICK_HZ;
    localparam int PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int MAX_LD   = (LONG_TICKS > DBL_TICKS) ? LONG_TICKS : DBL_TICKS;
    localparam int MAX_T    = (MAX_LD > REPEAT_TICKS) ? MAX_LD : REPEAT_TICKS;
    localparam int CW       = $clog2(MAX_T + 1);

    localparam logic [PW-1:0] PRESC_LAST  = PW'(PRESCALE - 1);
    localparam logic [CW-1:0] LONG_LAST   = CW'(LONG_TICKS - 1);
    localparam logic [CW-1:0] DBL_LAST    = CW'(DBL_TICKS - 1);
    localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_TICKS - 1);

    typedef enum logic [2:0] {
        IDLE,
        PRESS1,
        WAIT2,
        LONG_HOLD,
        WAIT_REL
    } state_t;

    state_t        state;
    logic [PW-1:0] presc;
    logic [CW-1:0] tick_cnt;
    logic          btn_q;
    logic          btn_q2;
    logic          tick;
    logic          rise;
    logic          fall;

    assign tick      = (presc == PRESC_LAST);
    assign rise      = btn_q & ~btn_q2;
    assign fall      = ~btn_q & btn_q2;
    assign o_pressed = btn_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // Sample registers reset to 1 so a button held through reset never looks like a fresh press.
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_q    <= 1'b1;
            btn_q2   <= 1'b1;
            state    <= IDLE;
            tick_cnt <= '0;
            o_short  <= 1'b0;
            o_double <= 1'b0;
            o_long   <= 1'b0;
            o_repeat <= 1'b0;
        end else begin
            btn_q    <= i_btn;
            btn_q2   <= btn_q;
            o_short  <= 1'b0;
            o_double <= 1'b0;
            o_long   <= 1'b0;
            o_repeat <= 1'b0;
            if (tick && !(&tick_cnt)) begin
                tick_cnt <= tick_cnt + 1'b1;
            end
            // Edges are tested before timeouts so an edge wins a same-cycle race with the final tick.
            case (state)
                IDLE: begin
                    if (rise) begin
                        state    <= PRESS1;
                        tick_cnt <= '0;
                    end
                end
                PRESS1: begin
                    if (fall) begin
                        state    <= WAIT2;
                        tick_cnt <= '0;
                    end else if (tick && tick_cnt == LONG_LAST) begin
                        state    <= LONG_HOLD;
                        tick_cnt <= '0;
                        o_long   <= 1'b1;
                    end
                end
                WAIT2: begin
                    if (rise) begin
                        state    <= WAIT_REL;
                        tick_cnt <= '0;
                        o_double <= 1'b1;
                    end else if (tick && tick_cnt == DBL_LAST) begin
                        state    <= IDLE;
                        tick_cnt <= '0;
                        o_short  <= 1'b1;
                    end
                end
                LONG_HOLD: begin
                    if (fall) begin
                        state    <= IDLE;
                        tick_cnt <= '0;
                    end else if (tick && tick_cnt == REPEAT_LAST) begin
                        tick_cnt <= '0;
                        o_repeat <= 1'b1;
                    end
                end
                WAIT_REL: begin
                    if (fall) begin
                        state    <= IDLE;
                        tick_cnt <= '0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    tick_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_btn_event_decoder.sv
// tb/tb_btn_event_decoder.sv - gesture model vs btn_event_decoder, directed scenarios plus random button traffic
module tb_btn_event_decoder;

    localparam int PRESCALE = 10;
    localparam int LONG_T   = 8;
    localparam int DBL_T    = 4;
    localparam int REP_T    = 3;

    localparam int P_IDLE = 0;
    localparam int P_PRESS = 1;
    localparam int P_GAP = 2;
    localparam int P_HOLD = 3;
    localparam int P_REL = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic i_btn = 1'b0;
    logic o_short, o_double, o_long, o_repeat, o_pressed;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    btn_event_decoder #(
        .CLK_FREQ(1000),
        .TICK_HZ(100),
        .LONG_TICKS(LONG_T),
        .DBL_TICKS(DBL_T),
        .REPEAT_TICKS(REP_T)
    ) dut (
        .clk(clk),
        .reset(reset),
        .i_btn(i_btn),
        .o_short(o_short),
        .o_double(o_double),
        .o_long(o_long),
        .o_repeat(o_repeat),
        .o_pressed(o_pressed)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk_range(input string nm, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d..%0d (cycle %0d)", nm, act, lo, hi, cyc);
        end
    endtask

    // Gesture model: phase plus ticks elapsed in that phase, and the tick phase since reset.
    bit m_valid = 0;
    bit m_h1, m_h2;
    int m_n, m_phase, m_ticks;
    bit e_short, e_double, e_long, e_repeat, e_pressed;

    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            m_h1 = 1; m_h2 = 1; m_n = 0; m_phase = P_IDLE; m_ticks = 0;
            e_short = 0; e_double = 0; e_long = 0; e_repeat = 0; e_pressed = 1;
            m_valid = 1;
        end else begin
            bit tk, rs, fl, restart;
            int nxt;
            tk = (m_n == PRESCALE - 1);
            rs = m_h1 && !m_h2;
            fl = !m_h1 && m_h2;
            nxt = m_phase;
            restart = 0;
            e_short = 0; e_double = 0; e_long = 0; e_repeat = 0;
            case (m_phase)
                P_IDLE:  if (rs) nxt = P_PRESS;
                P_PRESS: if (fl) nxt = P_GAP;
                         else if (tk && m_ticks + 1 == LONG_T) begin nxt = P_HOLD; e_long = 1; end
                P_GAP:   if (rs) begin nxt = P_REL; e_double = 1; end
                         else if (tk && m_ticks + 1 == DBL_T) begin nxt = P_IDLE; e_short = 1; end
                P_HOLD:  if (fl) nxt = P_IDLE;
                         else if (tk && m_ticks + 1 == REP_T) begin e_repeat = 1; restart = 1; end
                default: if (fl) nxt = P_IDLE;
            endcase
            if (nxt != m_phase || restart) m_ticks = 0;
            else if (tk) m_ticks++;
            m_phase = nxt;
            m_h2 = m_h1;
            m_h1 = i_btn;
            m_n = (m_n + 1) % PRESCALE;
            e_pressed = m_h1;
        end
    end

    int cnt_short, cnt_double, cnt_long, cnt_rep;
    int t_short, t_double, t_long;
    int rep_t[$];

    always @(negedge clk) begin
        if (m_valid) begin
            chk("o_short", o_short, e_short);
            chk("o_double", o_double, e_double);
            chk("o_long", o_long, e_long);
            chk("o_repeat", o_repeat, e_repeat);
            chk("o_pressed", o_pressed, e_pressed);
            if (o_short === 1'b1) begin cnt_short++; t_short = cyc; end
            if (o_double === 1'b1) begin cnt_double++; t_double = cyc; end
            if (o_long === 1'b1) begin cnt_long++; t_long = cyc; end
            if (o_repeat === 1'b1) begin cnt_rep++; rep_t.push_back(cyc); end
        end
    end

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_counts();
        cnt_short = 0; cnt_double = 0; cnt_long = 0; cnt_rep = 0;
        rep_t.delete();
    endtask

    task automatic expect_counts(input string nm, input int s, input int d, input int l, input int r);
        chk({nm, "_short_cnt"}, cnt_short, s);
        chk({nm, "_double_cnt"}, cnt_double, d);
        chk({nm, "_long_cnt"}, cnt_long, l);
        chk({nm, "_repeat_cnt"}, cnt_rep, r);
    endtask

    task automatic click(input int n);
        i_btn = 1;
        hold(n);
        i_btn = 0;
    endtask

    initial begin
        int t_ref, k;
        hold(3);
        chk("reset_pressed", o_pressed, 1);
        chk("reset_pulses", {o_short, o_double, o_long, o_repeat}, 0);
        reset = 0;
        hold(10);

        // Scenario 1: single click
        clear_counts();
        click(30);
        t_ref = cyc;
        hold(60);
        expect_counts("s1", 1, 0, 0, 0);
        chk_range("s1_short_latency", t_short - t_ref, 30, 42);

        // Scenario 2: double click
        clear_counts();
        click(20);
        hold(20);
        i_btn = 1;
        t_ref = cyc;
        hold(20);
        i_btn = 0;
        hold(60);
        expect_counts("s2", 0, 1, 0, 0);
        chk("s2_double_latency", t_double - t_ref, 2);

        // Scenario 3: long press with auto-repeat
        clear_counts();
        i_btn = 1;
        t_ref = cyc;
        hold(200);
        i_btn = 0;
        hold(60);
        chk("s3_long_cnt", cnt_long, 1);
        chk_range("s3_long_latency", t_long - t_ref, 70, 82);
        chk_range("s3_repeat_cnt", cnt_rep, 3, 4);
        chk("s3_short_cnt", cnt_short, 0);
        for (int i = 0; i < rep_t.size(); i++)
            chk("s3_repeat_gap", rep_t[i] - ((i == 0) ? t_long : rep_t[i-1]), 30);

        // Scenario 4: edges coincide with the final tick in PRESS1 and WAIT2
        clear_counts();
        i_btn = 1;
        k = 0;
        while (!(m_phase == P_PRESS && m_ticks == LONG_T - 1 && m_n == PRESCALE - 2) && k < 300) begin
            hold(1); k++;
        end
        chk("s4_press_sync_found", k < 300, 1);
        i_btn = 0;
        k = 0;
        while (!(m_phase == P_GAP && m_ticks == DBL_T - 1 && m_n == PRESCALE - 2) && k < 300) begin
            hold(1); k++;
        end
        chk("s4_gap_sync_found", k < 300, 1);
        i_btn = 1;
        hold(20);
        i_btn = 0;
        hold(60);
        expect_counts("s4", 0, 1, 0, 0);

        // Scenario 5: reset during PRESS1 with the button held
        clear_counts();
        i_btn = 1;
        hold(20);
        reset = 1;
        hold(1);
        chk("s5_reset_pulses", {o_short, o_double, o_long, o_repeat}, 0);
        reset = 0;
        hold(30);
        i_btn = 0;
        hold(80);
        expect_counts("s5", 0, 0, 0, 0);
        clear_counts();
        click(30);
        hold(60);
        expect_counts("s5_after", 1, 0, 0, 0);

        // Scenario 6: gap too long for a double click
        clear_counts();
        click(20);
        hold(50);
        click(20);
        hold(60);
        expect_counts("s6", 2, 0, 0, 0);

        // Random button traffic with occasional reset, checked cycle by cycle against the model
        for (int s = 0; s < 60; s++) begin
            i_btn = ~i_btn;
            if ($urandom_range(0, 15) == 0) begin
                reset = 1;
                hold(1);
                reset = 0;
            end
            hold($urandom_range(1, 120));
        end
        i_btn = 0;
        hold(100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
